// File: rtl/dds_pkg.sv
// dds_pkg: shared types and default widths for the DDS sine front end.
package dds_pkg;
    typedef enum logic [1:0] {Q1 = 2'b00, Q2 = 2'b01, Q3 = 2'b10, Q4 = 2'b11} quadrant_t;
    localparam int LUT_ADDR_W      = 7;
    localparam int PHASE_W_DEFAULT = 16;
endpackage

// File: rtl/dds_phase_sequencer_tick_prescaler.sv
// tick_prescaler: one-cycle tick every DIV enabled cycles; count freezes while en is low.
module tick_prescaler #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
    logic [CW-1:0] count;
    assign tick = en && (count == CW'(DIV - 1));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else if (en) count <= tick ? '0 : count + 1'b1;
endmodule

// File: rtl/dds_phase_sequencer.sv
// dds_phase_sequencer: DDS phase accumulator emitting quarter-wave LUT address, invert flag and quadrant.
module dds_phase_sequencer
    import dds_pkg::*;
#(
    parameter int                 PHASE_W    = PHASE_W_DEFAULT,
    parameter int                 ADDR_W     = LUT_ADDR_W,
    parameter int                 SAMPLE_DIV = 1,
    parameter logic [PHASE_W-1:0] FTW_RESET  = PHASE_W'('h80)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               sync_clear,
    input  logic [PHASE_W-1:0] ftw_in,
    input  logic               ftw_valid,
    output logic               ftw_ready,
    output logic [ADDR_W-1:0]  lut_addr,
    output logic               lut_invert,
    output logic [1:0]         quadrant,
    output logic               sample_valid,
    output logic               phase_wrap
);
    logic               tick, pending, clear_req, do_clear, wrap, accept;
    logic [PHASE_W-1:0] phase, active_ftw, pending_ftw;
    logic [PHASE_W:0]   sum;
    logic [ADDR_W-1:0]  idx;
    quadrant_t          q;

    tick_prescaler #(.DIV(SAMPLE_DIV)) u_presc (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (enable),
        .tick (tick)
    );

    always_comb begin
        sum      = {1'b0, phase} + {1'b0, active_ftw};
        q        = quadrant_t'(phase[PHASE_W-1 -: 2]);
        idx      = phase[PHASE_W-3 -: ADDR_W];
        do_clear = clear_req || sync_clear;
        wrap     = tick && (do_clear || sum[PHASE_W]);
        accept   = ftw_valid && !pending;
    end

    assign ftw_ready = !pending;

    // A word accepted on a wrap edge waits for the following wrap, keeping phase continuity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase        <= '0;
            active_ftw   <= FTW_RESET;
            pending_ftw  <= '0;
            pending      <= 1'b0;
            clear_req    <= 1'b0;
            lut_addr     <= '0;
            lut_invert   <= 1'b0;
            quadrant     <= 2'b00;
            sample_valid <= 1'b0;
            phase_wrap   <= 1'b0;
        end else begin
            sample_valid <= tick;
            phase_wrap   <= wrap;
            clear_req    <= tick ? 1'b0 : do_clear;
            if (tick) begin
                lut_addr   <= (q == Q2 || q == Q4) ? ~idx : idx;
                lut_invert <= phase[PHASE_W-1];
                quadrant   <= q;
                phase      <= do_clear ? '0 : sum[PHASE_W-1:0];
            end
            if (wrap && pending) begin
                active_ftw <= pending_ftw;
                pending    <= 1'b0;
            end else if (accept) begin
                pending_ftw <= ftw_in;
                pending     <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dds_phase_sequencer.sv
// tb_dds_phase_sequencer: random and directed stimulus on SAMPLE_DIV=1 and SAMPLE_DIV=4 instances against a sample-level model.
module tb_dds_phase_sequencer;
    logic            clk = 0, rst_n = 0, enable = 0, sync_clear = 0, ftw_valid = 0;
    logic [15:0]     ftw_in = 0;
    logic [1:0]      ready, inv, sv, pw;
    logic [1:0][6:0] addr;
    logic [1:0][1:0] quad;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dds_phase_sequencer #(.SAMPLE_DIV(g == 0 ? 1 : 4)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .enable      (enable),
            .sync_clear  (sync_clear),
            .ftw_in      (ftw_in),
            .ftw_valid   (ftw_valid),
            .ftw_ready   (ready[g]),
            .lut_addr    (addr[g]),
            .lut_invert  (inv[g]),
            .quadrant    (quad[g]),
            .sample_valid(sv[g]),
            .phase_wrap  (pw[g])
        );
    end

    task automatic chk(string n, int k, int a, int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s[%0d] got=%0d want=%0d t=%0t", n, k, a, e, $time);
        end
    endtask

    // Model: phase as an integer mod 65536, one pending word, sticky clear request.
    int div[2] = '{1, 4};
    int m_ph[2], m_act[2], m_pend[2], m_pv[2], m_clr[2], m_cnt[2];
    int e_a[2], e_q[2], e_i[2], e_sv[2], e_w[2];

    function automatic void mstep(int k, bit r, bit en, bit sc, bit fv, int fin);
        bit tick, acc;
        int idx;
        if (!r) begin
            m_ph[k] = 0; m_act[k] = 'h80; m_pv[k] = 0; m_pend[k] = 0; m_clr[k] = 0; m_cnt[k] = 0;
            e_a[k] = 0; e_q[k] = 0; e_i[k] = 0; e_sv[k] = 0; e_w[k] = 0;
            return;
        end
        tick = en && m_cnt[k] == div[k] - 1;
        acc = fv && !m_pv[k];
        if (en) m_cnt[k] = tick ? 0 : m_cnt[k] + 1;
        e_sv[k] = tick;
        e_w[k] = 0;
        if (tick) begin
            e_q[k] = m_ph[k] / 16384;
            idx = (m_ph[k] / 128) % 128;
            e_a[k] = (e_q[k] % 2) ? 127 - idx : idx;
            e_i[k] = e_q[k] / 2;
            e_w[k] = (m_clr[k] || sc || m_ph[k] + m_act[k] > 65535) ? 1 : 0;
            m_ph[k] = (m_clr[k] || sc) ? 0 : (m_ph[k] + m_act[k]) % 65536;
            m_clr[k] = 0;
        end else if (sc) m_clr[k] = 1;
        if (e_w[k] && m_pv[k]) begin
            m_act[k] = m_pend[k]; m_pv[k] = 0;
        end else if (acc) begin
            m_pend[k] = fin; m_pv[k] = 1;
        end
    endfunction

    bit c_r, c_en, c_sc, c_fv;
    int c_fin;
    initial begin
        mstep(0, 0, 0, 0, 0, 0);
        mstep(1, 0, 0, 0, 0, 0);
        forever begin
            @(posedge clk);
            c_r = rst_n; c_en = enable; c_sc = sync_clear; c_fv = ftw_valid; c_fin = ftw_in;
            #1;
            for (int k = 0; k < 2; k++) begin
                mstep(k, c_r, c_en, c_sc, c_fv, c_fin);
                chk("lut_addr", k, addr[k], e_a[k]);
                chk("quadrant", k, quad[k], e_q[k]);
                chk("lut_invert", k, inv[k], e_i[k]);
                chk("sample_valid", k, sv[k], e_sv[k]);
                chk("phase_wrap", k, pw[k], e_w[k]);
                chk("ftw_ready", k, ready[k], m_pv[k] ? 0 : 1);
            end
        end
    end

    logic [6:0] a;
    logic [1:0] q;
    logic       w;
    task automatic next0();
        int n = 0;
        do begin @(negedge clk); n++; end while (!sv[0] && n < 10);
        chk("sample_present", 0, sv[0], 1);
        a = addr[0]; q = quad[0]; w = pw[0];
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_addr", 0, addr[0], 0);
        chk("rst_ready", 0, ready[0], 1);
        rst_n = 1; enable = 1;
        for (int s = 0; s < 512; s++) begin
            next0();
            chk("walk_addr", s, a, s < 128 ? s : s < 256 ? 255 - s : s < 384 ? s - 256 : 511 - s);
            chk("walk_quad", s, q, s / 128);
            chk("walk_inv", s, inv[0], s >= 256 ? 1 : 0);
            chk("walk_wrap", s, w, s == 511 ? 1 : 0);
        end
        for (int s = 0; s < 180; s++) next0();
        chk("pre_clear_addr", 0, a, 76);
        sync_clear = 1;
        next0();
        sync_clear = 0;
        chk("clear_addr", 0, a, 75);
        chk("clear_quad", 0, q, 1);
        chk("clear_wrap", 0, w, 1);
        next0();
        chk("post_clear_addr", 0, a, 0);
        chk("post_clear_quad", 0, q, 0);
        ftw_in = 16'h0100; ftw_valid = 1;
        @(negedge clk);
        ftw_in = 16'h0200;
        chk("ftw_ready_drop", 0, ready[0], 0);
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (pw[0]) break;
        end
        chk("ftw_wrap_seen", 0, pw[0], 1);
        chk("ftw_ready_rise", 0, ready[0], 1);
        @(negedge clk);
        chk("ftw_second_accept", 0, ready[0], 0);
        repeat (8) @(negedge clk);
        ftw_valid = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (c == 2000) rst_n = 0;
            if (c == 2002) rst_n = 1;
            if (c % 500 == 250) begin
                enable = 0;
                repeat (10) @(negedge clk);
            end
            enable = ($urandom % 10) != 0;
            sync_clear = ($urandom % 200) == 0;
            ftw_valid = ($urandom % 8) == 0;
            case ($urandom % 5)
                0: ftw_in = 16'h0080;
                1: ftw_in = 16'h0100;
                2: ftw_in = 16'hFFFF;
                3: ftw_in = 16'($urandom_range(1, 65535));
                default: ftw_in = ($urandom % 8 == 0) ? 16'h0 : 16'($urandom_range(16'h4000, 16'hFFFF));
            endcase
        end
        enable = 1; sync_clear = 0; ftw_valid = 0;
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (quad[0] == 1) break;
        end
        chk("reach_q2", 0, quad[0], 1);
        ftw_in = 16'h1234; ftw_valid = 1;
        @(negedge clk);
        ftw_valid = 0;
        chk("pend_before_rst", 0, ready[0], 0);
        rst_n = 0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("arst_addr", k, addr[k], 0);
            chk("arst_quad", k, quad[k], 0);
            chk("arst_sv", k, sv[k], 0);
            chk("arst_ready", k, ready[k], 1);
        end
        @(negedge clk);
        rst_n = 1;
        repeat (300) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
